// File: rtl/vespa_intc_pkg.sv
// Shared types and helpers for the VeSPA interrupt controller.
// Covers the handshake state enum and the lowest-set-bit search used by the priority encoder.
package vespa_intc_pkg;

    typedef enum logic {
        INTC_IDLE,
        INTC_REQ
    } intc_state_e;

    localparam int INTC_MAX_SRC  = 32;
    localparam int INTC_MAX_ID_W = 5;

    // Id reported when no bit is set; callers must qualify it with the found flag.
    localparam logic [INTC_MAX_ID_W-1:0] INTC_NONE = '0;

    typedef struct packed {
        logic                     found;
        logic [INTC_MAX_ID_W-1:0] id;
    } intc_lowest_t;

    function automatic intc_lowest_t lowest_set(input logic [INTC_MAX_SRC-1:0] vec);
        intc_lowest_t r;
        r.found = 1'b0;
        r.id    = INTC_NONE;
        for (int i = INTC_MAX_SRC - 1; i >= 0; i--) begin
            if (vec[i]) begin
                r.found = 1'b1;
                r.id    = i[INTC_MAX_ID_W-1:0];
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/vespa_intc_prio_enc.sv
// Fixed-priority encoder: reports the lowest set index of vec and whether any bit is set.
// Supports up to INTC_MAX_SRC inputs.
module vespa_intc_prio_enc
    import vespa_intc_pkg::*;
#(
    parameter int N    = 4,
    parameter int ID_W = 2
) (
    input  logic [N-1:0]    vec,
    output logic            valid,
    output logic [ID_W-1:0] id
);

    logic [INTC_MAX_SRC-1:0] vec_ext;
    intc_lowest_t            r;

    always_comb begin
        vec_ext          = '0;
        vec_ext[N-1:0]   = vec;
        r                = lowest_set(vec_ext);
        valid            = r.found;
        id               = ID_W'(r.id);
    end

endmodule

// File: rtl/vespa_intc.sv
// VeSPA interrupt controller: synchronises, masks and latches sources, then offers one vector over req/ack.
// Build with VESPA_INTC_NESTING_EN to allow higher-priority sources to preempt those in service.
module vespa_intc
    import vespa_intc_pkg::*;
#(
    parameter int N_SRC       = 4,
    parameter int ID_W        = (N_SRC > 1) ? $clog2(N_SRC) : 1,
    parameter int SYNC_STAGES = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [N_SRC-1:0] int_sources,
    input  logic             ea,
    input  logic [N_SRC-1:0] en,
    input  logic [N_SRC-1:0] edge_mode,
    input  logic             int_ack_attended,
    input  logic             int_ack_complete,
    output logic             int_req,
    output logic [ID_W-1:0]  int_number,
    output logic             int_pending,
    output logic [N_SRC-1:0] in_service
);

    intc_state_e      state, state_next;
    logic [N_SRC-1:0] s, act, act_q, pending, in_service_q;
    logic [N_SRC-1:0] pending_d, in_service_d, num_oh, svc_oh, elig, cand;
    logic [ID_W-1:0]  int_number_q, win_id, svc_id;
    logic             int_pending_q, win_valid, svc_valid;
    logic             load_number, attend_fire, complete_fire;

    if (SYNC_STAGES == 0) begin : g_nosync
        assign s = int_sources;
    end else begin : g_sync
        logic [N_SRC-1:0] sync_q [SYNC_STAGES];
        always_ff @(posedge clk) begin
            if (rst) begin
                for (int k = 0; k < SYNC_STAGES; k++) sync_q[k] <= '0;
            end else begin
                sync_q[0] <= int_sources;
                for (int k = 1; k < SYNC_STAGES; k++) sync_q[k] <= sync_q[k-1];
            end
        end
        assign s = sync_q[SYNC_STAGES-1];
    end

    assign act = s & en & {N_SRC{ea}};

    vespa_intc_prio_enc #(.N(N_SRC), .ID_W(ID_W)) u_win_enc (
        .vec   (cand),
        .valid (win_valid),
        .id    (win_id)
    );

    vespa_intc_prio_enc #(.N(N_SRC), .ID_W(ID_W)) u_svc_enc (
        .vec   (in_service_q),
        .valid (svc_valid),
        .id    (svc_id)
    );

    always_comb begin
        elig = '0;
        for (int i = 0; i < N_SRC; i++) begin
`ifdef VESPA_INTC_NESTING_EN
            elig[i] = ~svc_valid | (ID_W'(i) < svc_id);
`else
            elig[i] = ~svc_valid;
`endif
        end
        cand = pending & ~in_service_q & elig;
    end

    always_ff @(posedge clk) begin
        if (rst) state <= INTC_IDLE;
        else     state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            INTC_IDLE: if (win_valid)        state_next = INTC_REQ;
            INTC_REQ:  if (int_ack_attended) state_next = INTC_IDLE;
            default:                         state_next = INTC_IDLE;
        endcase
    end

    always_comb begin
        int_req       = (state == INTC_REQ);
        load_number   = (state == INTC_IDLE) && win_valid;
        attend_fire   = (state == INTC_REQ) && int_ack_attended;
        complete_fire = int_ack_complete && svc_valid;
    end

    // A new edge in the attend cycle must survive the attend clear, so set is OR-ed in last.
    always_comb begin
        num_oh       = '0;
        svc_oh       = '0;
        pending_d    = '0;
        for (int i = 0; i < N_SRC; i++) begin
            num_oh[i] = (int_number_q == ID_W'(i));
            svc_oh[i] = svc_valid && (svc_id == ID_W'(i));
            if (edge_mode[i])
                pending_d[i] = (pending[i] & ~(attend_fire & num_oh[i])) | (act[i] & ~act_q[i]);
            else
                pending_d[i] = act[i];
        end
        in_service_d = (in_service_q & ~(complete_fire ? svc_oh : '0))
                     | (attend_fire ? num_oh : '0);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            act_q         <= '0;
            pending       <= '0;
            in_service_q  <= '0;
            int_number_q  <= '0;
            int_pending_q <= 1'b0;
        end else begin
            act_q         <= act;
            pending       <= pending_d;
            in_service_q  <= in_service_d;
            if (load_number) int_number_q <= win_id;
            int_pending_q <= |(pending & ~in_service_q & ~(int_req ? num_oh : '0));
        end
    end

    assign int_number  = int_number_q;
    assign int_pending = int_pending_q;
    assign in_service  = in_service_q;

endmodule
